// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-wide RAM port controller: MEM op/length codes,
// the zero word and the controller's state and port-owner encodings.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_NOP  = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [1:0] MEM_SAVE = 2'd2;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the MEM
// stage, splitting each request into little-endian byte transfers.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IF_LEN = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_fin,
    output logic [31:0]       if_data,
    input  logic [1:0]        mem_op,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic              mem_fin,
    output logic [31:0]       mem_out,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    localparam logic [2:0] IF_N = 3'(IF_LEN);

    function automatic logic [2:0] lenToBytes(input logic [1:0] len);
        case (len)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    state_e              state_q, state_d;
    port_e               port_q, port_d;
    logic                load_q, load_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          k_q, k_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   ramA_q, ramA_d;
    logic [7:0]          ramDout_q, ramDout_d;
    logic                wr_q, wr_d;

    logic [2:0]          kNext;
    logic [1:0]          kNextLo;
    logic [1:0]          kPrevLo;

    assign kNext   = k_q + 3'd1;
    assign kNextLo = 2'(k_q + 3'd1);
    assign kPrevLo = 2'(k_q - 3'd1);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            port_q    <= PORT_IF;
            load_q    <= 1'b0;
            n_q       <= 3'd0;
            k_q       <= 3'd0;
            addr_q    <= '0;
            data_q    <= ZeroWord;
            asm_q     <= ZeroWord;
            ramA_q    <= '0;
            ramDout_q <= 8'h00;
            wr_q      <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            port_q    <= port_d;
            load_q    <= load_d;
            n_q       <= n_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            asm_q     <= asm_d;
            ramA_q    <= ramA_d;
            ramDout_q <= ramDout_d;
            wr_q      <= wr_d;
        end
    end

    // RAM-side outputs are registered one cycle ahead: the cycle that decides
    // byte k+1 loads its address/data so it appears on the pins next cycle.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        load_d    = load_q;
        n_d       = n_q;
        k_d       = k_q;
        addr_d    = addr_q;
        data_d    = data_q;
        asm_d     = asm_q;
        ramA_d    = ramA_q;
        ramDout_d = ramDout_q;
        wr_d      = wr_q;

        case (state_q)
            IDLE: begin
                ramA_d    = '0;
                ramDout_d = 8'h00;
                wr_d      = 1'b0;
                if (mem_op != MEM_NOP) begin
                    port_d = PORT_MEM;
                    load_d = (mem_op == MEM_LOAD);
                    n_d    = lenToBytes(mem_len);
                    k_d    = 3'd0;
                    addr_d = mem_addr;
                    data_d = mem_data;
                    asm_d  = ZeroWord;
                    ramA_d = mem_addr;
                    if (mem_op == MEM_LOAD) begin
                        state_d = READ;
                    end else begin
                        state_d   = WRITE;
                        wr_d      = 1'b1;
                        ramDout_d = mem_data[7:0];
                    end
                end else if (if_req) begin
                    port_d  = PORT_IF;
                    load_d  = 1'b1;
                    n_d     = IF_N;
                    k_d     = 3'd0;
                    addr_d  = if_addr;
                    data_d  = ZeroWord;
                    asm_d   = ZeroWord;
                    ramA_d  = if_addr;
                    state_d = READ;
                end
            end

            // Byte k-1 returns while address k is on the pins, so READ runs N+1 cycles.
            READ: begin
                if (k_q != 3'd0) begin
                    asm_d[{kPrevLo, 3'b000} +: 8] = ram_din;
                end
                if (k_q == n_q) begin
                    state_d = DONE;
                    ramA_d  = '0;
                end else begin
                    k_d    = kNext;
                    ramA_d = (kNext < n_q) ? addr_q + ADDR_W'(kNext) : '0;
                end
            end

            WRITE: begin
                if (k_q == 3'(n_q - 3'd1)) begin
                    state_d   = DONE;
                    ramA_d    = '0;
                    ramDout_d = 8'h00;
                    wr_d      = 1'b0;
                end else begin
                    k_d       = kNext;
                    ramA_d    = addr_q + ADDR_W'(kNext);
                    ramDout_d = data_q[{kNextLo, 3'b000} +: 8];
                    wr_d      = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // fin is gated by rdy_in so a frozen DONE cycle cannot look like repeated pulses.
    always_comb begin
        if_fin  = rdy_in && (state_q == DONE) && (port_q == PORT_IF);
        mem_fin = rdy_in && (state_q == DONE) && (port_q == PORT_MEM);
        if_data = if_fin ? asm_q : ZeroWord;
        mem_out = (mem_fin && load_q) ? asm_q : ZeroWord;
    end

    assign ram_a    = ramA_q;
    assign ram_dout = ramDout_q;
    assign ram_wr   = wr_q & rdy_in;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- Arbitrates and sequences the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Splits each byte/half/word request into consecutive little-endian byte transfers and reassembles load data.
- Returns a one-cycle `fin` pulse with the result to the requester.
- Sits between IF/MEM and the top-level RAM pins; MEM's `memctl_*` outputs connect directly to the `mem_*` ports below.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- IF_LEN, 4, bytes per instruction fetch (fixed word)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low freezes the controller
- if_req  in  1  fetch request, held until if_fin
- if_addr  in  32  fetch byte address
- if_fin  out  1  one-cycle pulse: fetch complete
- if_data  out  32  fetched word, valid with if_fin
- mem_op  in  2  `MEM_NOP`=0, `MEM_LOAD`=1, `MEM_SAVE`=2; held until mem_fin
- mem_len  in  2  `MEM_BYTE`=0 (1 byte), `MEM_HALF`=1 (2 bytes), `MEM_WORD`=2 (4 bytes)
- mem_addr  in  32  data byte address
- mem_data  in  32  store data; low bytes used
- mem_fin  out  1  one-cycle pulse: load/store complete
- mem_out  out  32  raw load bytes, zero-extended; valid with mem_fin
- ram_din  in  8  RAM read byte
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write, 0 = read

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE:** arbitrates between the two ports.
  - MEM (op≠NOP) beats if_req. IF waits, holding its request.
  - On accept: latch port id, op, byte count N, addr, data; clear byte index k and the assembly register.
  - Go to READ (load or fetch) or WRITE (store).
- **READ:**
  - Present ram_a = addr+k with ram_wr=0 for k = 0..N-1, one byte per cycle.
  - Each byte arrives on ram_din the cycle after its address and is stored into bits [8k+7:8k].
  - After the last byte is captured, go to DONE.
- **WRITE:**
  - Present ram_a = addr+k, ram_dout = data[8k+7:8k], ram_wr=1 for k = 0..N-1.
  - After the last byte, go to DONE.
- **DONE:**
  - Pulse the owning port's fin; drive its data output (loads only).
  - No request is accepted in this cycle, because the finishing requester's request is still asserted.
  - Go to IDLE.
- Result formatting:
  - mem_out/if_data bits above 8N are 0. Sign extension belongs to MEM.
  - mem_out is 0 for stores.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Outputs not owned by the active transfer are 0: ram_wr, ram_dout, the idle port's fin/data.
- rdy_in low:
  - All registers hold.
  - ram_wr output = wr_q & rdy_in, so no write happens while frozen.
  - The transfer resumes exactly where it stopped.
- Requests dropped mid-transfer are ignored; the latched transfer completes.
- Reset (also mid-transfer):
  - State returns to IDLE.
  - if_fin, mem_fin, ram_wr = 0; ram_a, ram_dout, if_data, mem_out = 0.
  - A partial store is not rolled back.

## Timing
- Cycle t0 is the IDLE cycle in which the request is sampled. All RAM-side outputs are registered.
- Load of N bytes:
  - Addresses in cycles t0+1 .. t0+N.
  - Bytes captured at the end of cycles t0+2 .. t0+N+1.
  - DONE/fin in t0+N+2. Word load or fetch: fin at t0+6.
- Store of N bytes:
  - Writes in cycles t0+1 .. t0+N.
  - fin in t0+N+1. Word store: fin at t0+5.
- Earliest next accept is t0+N+3 (load) or t0+N+2 (store).
- A pending IF request is served at that point if MEM has withdrawn.
- A freeze of F cycles adds exactly F cycles to every later event.

## Structure
- Shared defines header (`include`d by MEM and mem_ctrl): `MEM_NOP`/`MEM_LOAD`/`MEM_SAVE`, `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`, `ZeroWord`, FSM state encodings.
- Single module, no sub-module. Byte-count decode (len→N) is an inline function.

## Test plan
- **Word load:** RAM[0x100..0x103] = 78 56 34 12; mem_op=LOAD, len=WORD, addr=0x100 at t0 → ram_a 0x100..0x103 in t0+1..t0+4, mem_fin at t0+6 with mem_out=0x12345678, if_fin=0.
- **Store half then byte load:** store len=HALF, addr=0x200, data=0xCAFEBEEF → ram_wr=1 with bytes EF, BE at 0x200, 0x201; fin at t0+3; RAM[0x202] unchanged. Then load BYTE at 0x201 → mem_out=0x000000BE.
- **Contention:** if_req (addr 0x0) and mem LOAD WORD (addr 0x40) asserted together → MEM served first (mem_fin at t0+6); IF accepted at t0+7; if_fin at t0+13 with the word from 0x0.
- **Freeze:** rdy_in low for 3 cycles during byte 2 of a word store → ram_wr=0 while low; bytes 2-3 written after; fin at t0+8; RAM contents correct.
- **Reset mid-load:** rst_in high at t0+3 → next cycle IDLE, all outputs 0, no fin. A new fetch issued after reset completes normally with if_fin 6 cycles after its request.
- **Held request:** MEM keeps op=LOAD through its DONE cycle → no re-accept in DONE. If MEM drops the request the cycle after, exactly one fin occurs and IF is then accepted.
